// File: rtl/fifo_mul_consumer_if.sv
// Handshake bundle between the FIFO read side, the multiplier consumer and
// the downstream result sink. The master side is the consumer itself.
interface fifo_mul_consumer_if #(
  parameter int OP_LEN  = 8,
  parameter int CNT_LEN = 16
);
  logic [2*OP_LEN-1:0] fifo_data;
  logic                fifo_empty;
  logic                fifo_rd_en;
  logic [2*OP_LEN-1:0] res_data;
  logic                res_valid;
  logic                res_ready;
  logic                busy;
  logic [CNT_LEN-1:0]  done_count;

  modport master (
    input  fifo_data, fifo_empty, res_ready,
    output fifo_rd_en, res_data, res_valid, busy, done_count
  );

  modport slave (
    output fifo_data, fifo_empty, res_ready,
    input  fifo_rd_en, res_data, res_valid, busy, done_count
  );
endinterface

// File: rtl/fifo_mul_consumer.sv
// FIFO read-side consumer: pops one {B,A} word, multiplies A*B with an
// OP_LEN-cycle shift-add loop and offers the product on a valid/ready port.
// Only one operand pair is in flight, so downstream backpressure stalls pops.
module fifo_mul_consumer #(
  parameter int OP_LEN  = 8,
  parameter int CNT_LEN = 16
) (
  input  logic clk,
  input  logic reset,   // asynchronous, active-low
  fifo_mul_consumer_if.master bus
);
  localparam int CW = $clog2(OP_LEN + 1);
  localparam int DW = 2 * OP_LEN;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_POP  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_MUL  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]         state_q,    state_d;
  logic               rd_en_q,    rd_en_d;
  logic [DW-1:0]      mcand_q,    mcand_d;
  logic [OP_LEN-1:0]  mplier_q,   mplier_d;
  logic [DW-1:0]      acc_q,      acc_d;
  logic [CW-1:0]      cnt_q,      cnt_d;
  logic [DW-1:0]      res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
  logic [CNT_LEN-1:0] done_q,     done_d;
  logic [DW-1:0]      acc_sum;

  // Next-state and datapath: one shift-add step per MUL cycle, no early exit.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    done_d      = done_q;
    acc_sum     = '0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.fifo_empty) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // FIFO data_out became valid at the end of the POP cycle.
        mcand_d  = {{OP_LEN{1'b0}}, bus.fifo_data[OP_LEN-1:0]};
        mplier_d = bus.fifo_data[DW-1:OP_LEN];
        acc_d    = '0;
        cnt_d    = CW'(OP_LEN);
        state_d  = ST_MUL;
      end
      ST_MUL: begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          res_data_d  = acc_sum;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          done_d      = done_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pop request is registered and tracks the POP state exactly.
    rd_en_d = (state_d == ST_POP);
  end

  // State register with asynchronous clear; an in-flight pair is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done_count = done_q;
endmodule

// File: tb/tb_fifo_mul_consumer.sv
// Directed bench for fifo_mul_consumer with a small behavioural FIFO read side.
// Uses CNT_LEN=4 so the done_count wrap is reachable in 16 results.
module tb_fifo_mul_consumer;
  localparam int OP_LEN  = 8;
  localparam int CNT_LEN = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic res_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_count = 0;

  logic [15:0] mem [0:63];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr = '0;
  logic [15:0] data_out = '0;

  fifo_mul_consumer_if #(.OP_LEN(OP_LEN), .CNT_LEN(CNT_LEN)) bus ();

  assign bus.fifo_data  = data_out;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.res_ready  = res_ready;

  fifo_mul_consumer #(.OP_LEN(OP_LEN), .CNT_LEN(CNT_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // FIFO read side: data_out updates at the end of the pop cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en) begin
      pop_count <= pop_count + 1;
      if (wr_ptr != rd_ptr) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1'b1;
  endtask

  task automatic wait_pop(output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("pop_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int tp, tv, tp2, tp3, pc0;
    bit ok_stable, ok_idle;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_data",  32'(bus.res_data), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.done_count), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: 5*3, latency and single pop
    res_ready = 1'b1;
    pc0 = pop_count;
    push(16'h0305);
    wait_pop(tp);
    wait_valid(tv);
    chk("t1_latency", 32'(tv - tp), 32'd10);
    chk("t1_data", 32'(bus.res_data), 32'h000F);
    @(negedge clk);
    chk("t1_count", 32'(bus.done_count), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_pops", 32'(pop_count - pc0), 32'd1);

    // 2: max operands and zero multiplier
    push(16'hFFFF);
    wait_pop(tp);
    wait_valid(tv);
    chk("t2_latency", 32'(tv - tp), 32'd10);
    chk("t2_ffxff", 32'(bus.res_data), 32'hFE01);
    push(16'h00FF);
    wait_pop(tp);
    wait_valid(tv);
    chk("t2_latency0", 32'(tv - tp), 32'd10);
    chk("t2_ffx00", 32'(bus.res_data), 32'h0000);
    @(negedge clk);

    // 3: backpressure stalls the FIFO
    res_ready = 1'b0;
    pc0 = pop_count;
    push(16'h0202);
    push(16'h0303);
    push(16'h0404);
    wait_valid(tv);
    chk("t3_first", 32'(bus.res_data), 32'h0004);
    ok_stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== 16'h0004) ok_stable = 1'b0;
    end
    chk("t3_hold", 32'(ok_stable), 32'd1);
    chk("t3_one_pop", 32'(pop_count - pc0), 32'd1);
    res_ready = 1'b1;
    wait_pop(tp2);
    wait_valid(tv);
    chk("t3_second", 32'(bus.res_data), 32'h0009);
    wait_pop(tp3);
    chk("t3_spacing", 32'(tp3 - tp2), 32'd12);
    wait_valid(tv);
    chk("t3_third", 32'(bus.res_data), 32'h0010);
    @(negedge clk);
    chk("t3_count", 32'(bus.done_count), 32'd6);

    // 4: FIFO stays empty
    ok_idle = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en || bus.busy || bus.res_valid) ok_idle = 1'b0;
    end
    chk("t4_idle", 32'(ok_idle), 32'd1);

    // 5: async reset during the 4th MUL cycle
    push(16'h0707);
    wait_pop(tp);
    repeat (5) @(negedge clk);
    chk("t5_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_valid", 32'(bus.res_valid), 32'd0);
    chk("t5_data", 32'(bus.res_data), 32'd0);
    chk("t5_count", 32'(bus.done_count), 32'd0);
    chk("t5_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push(16'h0203);
    wait_pop(tp);
    wait_valid(tv);
    chk("t5_after", 32'(bus.res_data), 32'h0006);
    @(negedge clk);
    chk("t5_count1", 32'(bus.done_count), 32'd1);

    // 6: done_count wraps (CNT_LEN=4): 15 more results
    for (int i = 1; i <= 15; i++) push({8'(i), 8'd3});
    for (int i = 1; i <= 15; i++) begin
      wait_valid(tv);
      chk("t6_prod", 32'(bus.res_data), 32'(3 * i));
      if (i == 14) begin
        @(negedge clk);
        chk("t6_count15", 32'(bus.done_count), 32'd15);
      end
    end
    @(negedge clk);
    chk("t6_wrap", 32'(bus.done_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
